cnn_stream_mem: RTL and testbench
=================================

Name: cnn_stream_mem

Overview:
Parametrised successor to the CNN peripheral memory: a word-addressed buffer of DEPTH words × DATA_W bits, loaded by the HPS over an Avalon-MM slave interface.
- Host side adds registered readback and a control/status register bank.
- Adds a DMA-style stream engine that pushes a programmed window of words (BASE, LEN) to the CNN datapath over a valid/ready handshake.
- Sits between the lightweight HPS bridge and the CNN compute core.

Parameters:
DATA_W, 8, word and register width; must be ≥ AW.
DEPTH, 256, RAM words; power of two ≥ 4.
AW, $clog2(DEPTH), RAM word-address width (derived, do not override).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
chipselect  in  1  Avalon slave select.
address  in  AW+1  MSB=0: RAM word address[AW-1:0]; MSB=1: register offset address[1:0].
write  in  1  write strobe (qualified by chipselect).
writedata  in  DATA_W  write data.
read  in  1  read strobe (qualified by chipselect).
readdata  out  DATA_W  read data, registered.
s_data  out  DATA_W  stream word.
s_valid  out  1  stream word valid.
s_ready  in  1  consumer ready.
s_last  out  1  high with final word of a run.

Behaviour:
- Reset (reset=0, async): readdata, s_data, s_valid, s_last, BASE, LEN, STATUS all 0; FSM to IDLE. RAM contents are not reset.
- Host RAM write: cs&write&MSB=0 writes RAM[addr] at the clock edge. Allowed at any time, including while streaming.
- Host read: cs&read presented in cycle N gives readdata in cycle N+1; readdata holds until the next read.
- Register map (MSB=1):
  - 0 CTRL: write bit0=1 pulses start; reads 0.
  - 1 BASE: start word address (low AW bits used; upper bits read 0).
  - 2 LEN: word count (low AW bits; 0 means zero words).
  - 3 STATUS: bit0 busy, bit1 done. Writing bit1=1 clears done.
- RAM has one write port (host) and one synchronous read port, shared by host reads and the stream engine. A host read has priority; a stream fetch colliding with it retries next cycle.
- Start while busy: ignored. BASE/LEN writes while busy update the registers but affect only the next run.
- FSM states:
  - IDLE: on start, latch ptr=BASE, cnt=LEN, clear done. If LEN=0, set done next cycle and stay IDLE; else go to FETCH, busy=1.
  - FETCH: issue read of RAM[ptr] (unless a host read collides). Next cycle go to WAIT.
  - WAIT: capture RAM output into s_data, assert s_valid, set s_last=(cnt==1). Go to OUT.
  - OUT: hold s_data/s_valid/s_last stable until s_valid&s_ready.
    - On handshake: ptr=(ptr+1) mod DEPTH, cnt=cnt−1, drop s_valid.
    - If that was the last word: done=1, busy=0, go to IDLE; else go to FETCH.
- Throughput: 1 word per 3 cycles with s_ready held high. Latency from start write to first s_valid is 3 cycles.
- Address wrap: a run with BASE+LEN>DEPTH wraps to word 0.
- Stream data is read at fetch time, so a host write to a word not yet fetched is visible in the stream.
- Async reset mid-run aborts the run immediately: s_valid=0, STATUS=0.

Optional Feature:
CNN_STREAM_IRQ_EN
- Defined: adds output port irq (1 bit). CTRL bit1 is an R/W irq-enable bit (CTRL reads return it in bit1). irq = done & enable, a level that clears when done is cleared or a new run starts.
- Undefined: no irq port; CTRL bit1 is ignored and reads 0.

Test Plan:
1. Write RAM[0..3]=0x11,0x22,0x33,0x44, then read addr 2 -> readdata=0x33 exactly one cycle after read.
2. BASE=0, LEN=4, start, s_ready=1 -> s_data 0x11,0x22,0x33,0x44; s_last only on 0x44; STATUS reads 0x2 afterwards.
3. DEPTH=256: BASE=254, LEN=4 with RAM[254,255,0,1]=A,B,C,D -> stream A,B,C,D (wrap).
4. s_ready low for 5 cycles mid-run -> s_data/s_valid/s_last stable; no words lost or duplicated; start pulse during the run is ignored.
5. LEN=0, start -> no s_valid, done=1 one cycle later. Separately, reset asserted mid-run -> s_valid=0 and STATUS=0 immediately.
6. Host read issued in the same cycle as a FETCH -> host gets correct data; stream word order unchanged, delayed by 1 cycle.

Source files
------------

// File: rtl/cnn_stream_mem.sv
// Word-addressed RAM loaded over Avalon-MM, with a BASE/LEN stream engine feeding the CNN datapath.
// Optional irq output and CTRL irq-enable bit are built when CNN_STREAM_IRQ_EN is defined.
module cnn_stream_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [AW:0]       address,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] s_data,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              s_last
`ifdef CNN_STREAM_IRQ_EN
  ,
  output logic              irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_q;
  logic [AW-1:0]     r_base;
  logic [AW-1:0]     r_len;
  logic [AW-1:0]     r_ptr;
  logic [AW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  state_t            r_state;

  logic              w_host_wr;
  logic              w_host_rd;
  logic              w_ram_sel;
  logic [1:0]        w_reg_off;
  logic              w_ram_wr;
  logic              w_ram_rd_host;
  logic              w_start;
  logic              w_clr_done;
  logic              w_fetch_ok;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_reg_rd;
  logic              w_unused;

  assign w_host_wr     = chipselect & write;
  assign w_host_rd     = chipselect & read;
  assign w_ram_sel     = ~address[AW];
  assign w_reg_off     = address[1:0];
  assign w_ram_wr      = w_host_wr & w_ram_sel;
  assign w_ram_rd_host = w_host_rd & w_ram_sel;
  assign w_start       = w_host_wr & address[AW] & (w_reg_off == 2'd0) & writedata[0];
  assign w_clr_done    = w_host_wr & address[AW] & (w_reg_off == 2'd3) & writedata[1];
  // Shared read port: a host RAM read steals it and the pending fetch waits a cycle.
  assign w_fetch_ok    = (r_state == ST_FETCH) & ~w_ram_rd_host;
  assign w_rd_addr     = w_ram_rd_host ? address[AW-1:0] : r_ptr;
  assign w_rd_data     = r_mem[w_rd_addr];
  assign w_unused      = ^writedata;

`ifdef CNN_STREAM_IRQ_EN
  logic r_irq_en;

  // Interrupt enable bit lives in CTRL bit1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_en <= 1'b0;
    end else if (w_host_wr && address[AW] && (w_reg_off == 2'd0)) begin
      r_irq_en <= writedata[1];
    end
  end

  assign irq = r_done & r_irq_en;
`endif

  // Host write port into the RAM array.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_mem[address[AW-1:0]] <= writedata;
    end
  end

  // BASE and LEN registers; writes while busy only affect the next run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base <= '0;
      r_len  <= '0;
    end else if (w_host_wr && address[AW]) begin
      case (w_reg_off)
        2'd1:    r_base <= writedata[AW-1:0];
        2'd2:    r_len  <= writedata[AW-1:0];
        default: ;
      endcase
    end
  end

  // Register-bank readback mux.
  always_comb begin
    w_reg_rd = '0;
    case (w_reg_off)
      2'd0: begin
`ifdef CNN_STREAM_IRQ_EN
        w_reg_rd[1] = r_irq_en;
`else
        w_reg_rd = '0;
`endif
      end
      2'd1:    w_reg_rd[AW-1:0] = r_base;
      2'd2:    w_reg_rd[AW-1:0] = r_len;
      2'd3:    w_reg_rd[1:0]    = {r_done, r_busy};
      default: w_reg_rd = '0;
    endcase
  end

  // Registered host readback, held until the next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata <= '0;
    end else if (w_host_rd) begin
      readdata <= w_ram_sel ? w_rd_data : w_reg_rd;
    end
  end

  // Stream engine: IDLE -> FETCH -> WAIT -> OUT, one word per pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ram_q <= '0;
      s_data  <= '0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
    end else begin
      if (w_clr_done) begin
        r_done <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_ptr <= r_base;
            r_cnt <= r_len;
            if (r_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (w_fetch_ok) begin
            r_ram_q <= w_rd_data;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          s_data  <= r_ram_q;
          s_valid <= 1'b1;
          s_last  <= (r_cnt == AW'(1));
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (s_ready) begin
            s_valid <= 1'b0;
            s_last  <= 1'b0;
            r_ptr   <= r_ptr + AW'(1);
            r_cnt   <= r_cnt - AW'(1);
            if (r_cnt == AW'(1)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_stream_mem.sv
// Scoreboard bench for cnn_stream_mem: stimulus pushes expected stream words and readbacks,
// a negedge monitor pops and compares them when the DUT presents data.
module tb_cnn_stream_mem;

  localparam int DATA_W = 8;
  localparam int AW     = 8;

  localparam logic [AW:0] REG_CTRL   = 9'h100;
  localparam logic [AW:0] REG_BASE   = 9'h101;
  localparam logic [AW:0] REG_LEN    = 9'h102;
  localparam logic [AW:0] REG_STATUS = 9'h103;

  logic              clk = 1'b0;
  logic              reset;
  logic              chipselect;
  logic [AW:0]       address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W:0]   sb_q[$];
  logic [DATA_W-1:0] rd_q[$];
  logic              rd_pend = 1'b0;

  cnn_stream_mem #(.DATA_W(DATA_W), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .read(read), .readdata(readdata),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [AW:0] a, input logic [DATA_W-1:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic host_read(input logic [AW:0] a, input logic [DATA_W-1:0] exp);
    rd_q.push_back(exp);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic expect_word(input logic [DATA_W-1:0] d, input logic last);
    sb_q.push_back({last, d});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!s_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Monitor: readback one cycle after a read, stream words on each handshake.
  always @(negedge clk) begin
    logic [DATA_W:0]   e;
    logic [DATA_W-1:0] r;
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        chk("readdata_unexpected", 1, 0);
      end else begin
        r = rd_q.pop_front();
        chk("readdata", readdata, r);
      end
    end
    rd_pend = reset && chipselect && read;
    if (reset && s_valid && s_ready) begin
      if (sb_q.size() == 0) begin
        chk("stream_unexpected", {s_last, s_data}, 0);
      end else begin
        e = sb_q.pop_front();
        chk("stream_data", s_data, e[DATA_W-1:0]);
        chk("stream_last", s_last, e[DATA_W]);
      end
    end
  end

  initial begin
    int lat;
    reset = 1'b0; chipselect = 1'b0; address = '0; write = 1'b0;
    writedata = '0; read = 1'b0; s_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_last", s_last, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_readdata", readdata, 0);
    host_read(REG_STATUS, 8'h00);
    host_read(REG_BASE, 8'h00);

    // Load and read back
    host_write(9'h000, 8'h11);
    host_write(9'h001, 8'h22);
    host_write(9'h002, 8'h33);
    host_write(9'h003, 8'h44);
    host_read(9'h002, 8'h33);
    host_read(REG_CTRL, 8'h00);

    // Basic run, latency check
    host_write(REG_BASE, 8'd0);
    host_write(REG_LEN, 8'd4);
    s_ready = 1'b1;
    expect_word(8'h11, 1'b0);
    expect_word(8'h22, 1'b0);
    expect_word(8'h33, 1'b0);
    expect_word(8'h44, 1'b1);
    host_write(REG_CTRL, 8'h01);
    wait_valid(lat);
    chk("start_latency", lat, 2);
    wait_drain();
    host_read(REG_STATUS, 8'h02);
    host_read(REG_LEN, 8'h04);

    // Wrap across DEPTH
    host_write(9'h0FE, 8'hA1);
    host_write(9'h0FF, 8'hB2);
    host_write(9'h000, 8'hC3);
    host_write(9'h001, 8'hD4);
    host_write(REG_BASE, 8'd254);
    expect_word(8'hA1, 1'b0);
    expect_word(8'hB2, 1'b0);
    expect_word(8'hC3, 1'b0);
    expect_word(8'hD4, 1'b1);
    host_write(REG_CTRL, 8'h01);
    wait_drain();
    host_read(REG_BASE, 8'hFE);

    // Backpressure stall plus ignored start
    host_write(9'h00A, 8'h5A);
    host_write(9'h00B, 8'h6B);
    host_write(9'h00C, 8'h7C);
    host_write(REG_BASE, 8'd10);
    host_write(REG_LEN, 8'd3);
    s_ready = 1'b0;
    expect_word(8'h5A, 1'b0);
    expect_word(8'h6B, 1'b0);
    expect_word(8'h7C, 1'b1);
    host_write(REG_CTRL, 8'h01);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", s_valid, 1);
      chk("stall_data", s_data, 8'h5A);
      chk("stall_last", s_last, 0);
      if (i == 2) host_write(REG_CTRL, 8'h01);
      else begin @(posedge clk); #1; end
    end
    host_read(REG_STATUS, 8'h01);
    s_ready = 1'b1;
    wait_drain();
    repeat (8) @(posedge clk);
    #1;
    chk("no_extra_words", s_valid, 0);
    host_read(REG_STATUS, 8'h02);

    // Zero-length run
    host_write(REG_STATUS, 8'h02);
    host_read(REG_STATUS, 8'h00);
    host_write(REG_LEN, 8'd0);
    host_write(REG_CTRL, 8'h01);
    chk("len0_no_valid", s_valid, 0);
    host_read(REG_STATUS, 8'h02);
    repeat (4) @(posedge clk);
    #1;
    chk("len0_still_idle", s_valid, 0);

    // Reset mid-run
    host_write(REG_LEN, 8'd4);
    host_write(REG_BASE, 8'd0);
    s_ready = 1'b0;
    host_write(REG_CTRL, 8'h01);
    wait_valid(lat);
    chk("pre_reset_valid", s_valid, 1);
    sb_q.delete();
    reset = 1'b0;
    #1;
    chk("reset_s_valid", s_valid, 0);
    chk("reset_s_last", s_last, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    host_read(REG_STATUS, 8'h00);
    host_read(REG_LEN, 8'h00);

    // Host read colliding with FETCH
    s_ready = 1'b1;
    host_write(REG_BASE, 8'd2);
    host_write(REG_LEN, 8'd2);
    expect_word(8'h33, 1'b0);
    expect_word(8'h44, 1'b1);
    host_write(REG_CTRL, 8'h01);
    host_read(9'h000, 8'hC3);
    wait_valid(lat);
    chk("collide_latency", lat, 2);
    wait_drain();
    host_read(REG_STATUS, 8'h02);

    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_empty", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
